// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types, opcode constants and helpers for the fetch front-end
// Contents:
//   inst_format_t  format class handed to decode for immediate generation
//   OPC_*          RV32 major opcodes recognised by the classifier
//   sat_add32      32-bit add that clamps at all-ones
package fetch_unit_pkg;

  typedef enum logic [2:0] {
    R_TYPE = 3'd0,
    I_TYPE = 3'd1,
    S_TYPE = 3'd2,
    B_TYPE = 3'd3,
    U_TYPE = 3'd4,
    J_TYPE = 3'd5
  } inst_format_t;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory and decode handshake bundle of the fetch unit
// Signals:
//   imem_req_valid/imem_req_ready/imem_addr  request channel to instruction memory
//   imem_rsp_valid/imem_rsp_data             in-order response channel (no backpressure)
//   id_valid/id_ready/id_pc/id_instruction/id_inst_fmt/id_illegal  decode channel
// Modports: master = fetch unit side, slave = memory + decode side
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic         imem_req_valid;
  logic         imem_req_ready;
  logic [31:0]  imem_addr;
  logic         imem_rsp_valid;
  logic [31:0]  imem_rsp_data;
  logic         id_valid;
  logic         id_ready;
  logic [31:0]  id_pc;
  logic [31:0]  id_instruction;
  inst_format_t id_inst_fmt;
  logic         id_illegal;

  modport master (
    output imem_req_valid, imem_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output id_valid, id_pc, id_instruction, id_inst_fmt, id_illegal,
    input  id_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  id_valid, id_pc, id_instruction, id_inst_fmt, id_illegal,
    output id_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous first-word-fall-through FIFO with single-cycle flush
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             empties the FIFO; a push in the same cycle is discarded
//   push, push_data   write request (accepted when not full, or full and popping)
//   pop               read request (ignored when empty)
//   head              oldest entry, valid while !empty
//   empty, count      occupancy status
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front-end: sequential PC, credit-limited requests, FWFT response buffer
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   redirect_valid, redirect_pc flush everything and restart at redirect_pc (low bits forced to 0)
//   bus (fetch_unit_if.master)  imem request/response and decode handshake
//   perf_fetched, perf_flushed  saturating event counters
// Build option: FETCH_PERF_CNT_EN enables the perf counters; otherwise they read 0.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  fetch_unit_if.master        bus,
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_flushed
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   pc;
  logic          run_q;
  logic [CW-1:0] drop_cnt;

  logic [31:0]   pcq_head;
  logic          pcq_empty;
  logic [CW-1:0] pcq_count;
  logic [63:0]   rsp_head;
  logic          rsp_empty;
  logic [CW-1:0] rsp_count;

  logic          req_fire;
  logic          rsp_drop;
  logic          rsp_keep;
  logic          pcq_pop;
  logic          id_fire;
  logic [CW:0]   in_use;

  // Every slot is spoken for from request accept until decode takes it:
  // requests still owed a discard, in-flight requests, and buffered responses.
  assign in_use = {1'b0, drop_cnt} + {1'b0, pcq_count} + {1'b0, rsp_count};

  // run_q keeps the request line low while reset is held and on the release cycle.
  assign bus.imem_req_valid = run_q && !redirect_valid && (in_use < (CW+1)'(FIFO_DEPTH));
  assign bus.imem_addr      = pc;

  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_drop = bus.imem_rsp_valid && (redirect_valid || (drop_cnt != '0));
  assign rsp_keep = bus.imem_rsp_valid && !rsp_drop;
  // Stale responses never had their PC kept, so only live ones pop the PC queue.
  assign pcq_pop  = bus.imem_rsp_valid && (drop_cnt == '0) && !pcq_empty;
  assign id_fire  = bus.id_valid && bus.id_ready && !redirect_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      run_q    <= 1'b0;
      drop_cnt <= '0;
    end else begin
      run_q <= 1'b1;
      if (redirect_valid) begin
        pc       <= redirect_pc & 32'hFFFF_FFFC;
        // Everything still in flight becomes garbage; a response arriving now is
        // already being discarded, so it leaves the tally.
        drop_cnt <= drop_cnt + pcq_count - CW'(bus.imem_rsp_valid);
      end else begin
        if (req_fire) pc <= pc + 32'd4;
        if (bus.imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_pc_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (req_fire),
    .push_data (pc),
    .pop       (pcq_pop),
    .head      (pcq_head),
    .empty     (pcq_empty),
    .count     (pcq_count)
  );

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(64)) u_rsp_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data ({pcq_head, bus.imem_rsp_data}),
    .pop       (id_fire),
    .head      (rsp_head),
    .empty     (rsp_empty),
    .count     (rsp_count)
  );

  assign bus.id_valid       = !rsp_empty;
  assign bus.id_pc          = rsp_empty ? 32'h0 : rsp_head[63:32];
  assign bus.id_instruction = rsp_empty ? 32'h0 : rsp_head[31:0];

  inst_format_t fmt;
  logic         known;

  always_comb begin
    fmt   = R_TYPE;
    known = 1'b1;
    case (bus.id_instruction[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_FENCE: fmt = I_TYPE;
      OPC_STORE:            fmt = S_TYPE;
      OPC_BRANCH:           fmt = B_TYPE;
      OPC_LUI, OPC_AUIPC:   fmt = U_TYPE;
      OPC_JAL:              fmt = J_TYPE;
      OPC_OP:               fmt = R_TYPE;
      default:              known = 1'b0;
    endcase
  end

  assign bus.id_inst_fmt = fmt;
  assign bus.id_illegal  = bus.id_valid && !known;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q;
  logic [31:0] flushed_q;
  logic [31:0] flush_inc;

  // A redirect throws away the whole buffer plus any response landing that cycle.
  assign flush_inc = (redirect_valid ? 32'(rsp_count) : 32'h0) + 32'(rsp_drop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_q <= 32'h0;
      flushed_q <= 32'h0;
    end else begin
      fetched_q <= sat_add32(fetched_q, 32'(id_fire));
      flushed_q <= sat_add32(flushed_q, flush_inc);
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_flushed = flushed_q;
`else
  assign perf_fetched = 32'h0;
  assign perf_flushed = 32'h0;
`endif
endmodule
